dec_trigger_csr: RTL and testbench

- Trigger CSR register file in the TLU: holds tselect and four mcontrol-type (type 2) triggers with their tdata2 compare values.
- Drives trigger_pkt_any to the decode-stage PC matchers and the LSU address matchers.
- Takes back commit-qualified match hits, sets sticky hit bits, resolves chaining and raises one registered trigger action per cycle.

---
 rtl/dec_trigger_csr.sv | 128 ++++++++++++
 tb/tb_dec_trigger_csr.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dec_trigger_csr.sv
// dec_trigger_csr: tselect/tdata1/tdata2 trigger CSRs, hit qualification and trigger action pulse.
// Optional chaining of trigger pairs 0/1 and 2/3 is enabled by defining DEC_TRIGGER_CHAIN_EN.
package dec_trigger_pkg;
    typedef struct packed {
        logic        select;
        logic        match;
        logic        store;
        logic        load;
        logic        execute;
        logic        m;
        logic [31:0] tdata2;
    } trigger_pkt_t;
endpackage

module dec_trigger_csr
    import dec_trigger_pkg::*;
#(
    parameter int         NTRIG   = 4,
    parameter logic [5:0] MASKMAX = 6'h1F
) (
    input  logic                   clk,
    input  logic                   rst_l,
    input  logic                   csr_wen,
    input  logic [11:0]            csr_addr,
    input  logic [31:0]            csr_wrdata,
    output logic [31:0]            csr_rddata,
    input  logic                   dbg_mode,
    input  logic [NTRIG-1:0]       i0_trigger_hit,
    input  logic [NTRIG-1:0]       i1_trigger_hit,
    output trigger_pkt_t [NTRIG-1:0] trigger_pkt_any,
    output logic                   trigger_dbg_req,
    output logic                   trigger_brk_req,
    output logic [NTRIG-1:0]       trigger_fired
);
`ifdef DEC_TRIGGER_CHAIN_EN
    localparam logic CHAIN_EN = 1'b1;
`else
    localparam logic CHAIN_EN = 1'b0;
`endif

    logic [1:0]             tselect;
    logic [NTRIG-1:0]       dmode, hit, sel, action, mt, m, exe, st, ld;
    logic [1:0]             chain;
    logic [NTRIG-1:0][31:0] tdata2;
    logic [NTRIG-1:0]       q0, fire;
    logic                   locked, wr_tsel, wr_td1, wr_td2, new_dmode, chain_rd, unused;

    // A chained pair fires together only when both members match.
    function automatic logic [3:0] qual(input logic [3:0] r, input logic [1:0] c);
        qual[0] = r[0] & (~c[0] | r[1]);
        qual[1] = c[0] ? r[0] & r[1] : r[1];
        qual[2] = r[2] & (~c[1] | r[3]);
        qual[3] = c[1] ? r[2] & r[3] : r[3];
    endfunction

    assign q0        = qual(i0_trigger_hit, chain);
    assign fire      = |q0 ? q0 : qual(i0_trigger_hit | i1_trigger_hit, chain);
    assign locked    = dmode[tselect] & ~dbg_mode;
    assign wr_tsel   = csr_wen & (csr_addr == 12'h7A0) & (csr_wrdata[31:2] == 30'b0);
    assign wr_td1    = csr_wen & (csr_addr == 12'h7A1) & ~locked;
    assign wr_td2    = csr_wen & (csr_addr == 12'h7A2) & ~locked;
    assign new_dmode = dbg_mode ? csr_wrdata[27] : dmode[tselect];
    assign chain_rd  = ~tselect[0] & chain[tselect[1]];
    assign unused    = ^{csr_wrdata[31:28], csr_wrdata[26:21], csr_wrdata[18:16], csr_wrdata[5:3]};

    always_comb begin
        csr_rddata = 32'b0;
        if (csr_addr == 12'h7A0)
            csr_rddata = {30'b0, tselect};
        else if (csr_addr == 12'h7A1)
            csr_rddata = {4'd2, dmode[tselect], MASKMAX, hit[tselect], sel[tselect], 3'b0,
                          3'b0, action[tselect], chain_rd, 3'b0, mt[tselect], m[tselect],
                          3'b0, exe[tselect], st[tselect], ld[tselect]};
        else if (csr_addr == 12'h7A2)
            csr_rddata = tdata2[tselect];
    end

    // Execute/load/store matching is suppressed while the core sits in debug mode.
    always_comb begin
        for (int i = 0; i < NTRIG; i++)
            trigger_pkt_any[i] = '{select: sel[i], match: mt[i], store: st[i] & ~dbg_mode,
                                   load: ld[i] & ~dbg_mode, execute: exe[i] & ~dbg_mode,
                                   m: m[i], tdata2: tdata2[i]};
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            tselect         <= '0;
            dmode           <= '0;
            hit             <= '0;
            sel             <= '0;
            action          <= '0;
            chain           <= '0;
            mt              <= '0;
            m               <= '0;
            exe             <= '0;
            st              <= '0;
            ld              <= '0;
            tdata2          <= '0;
            trigger_dbg_req <= 1'b0;
            trigger_brk_req <= 1'b0;
            trigger_fired   <= '0;
        end else begin
            if (wr_tsel)
                tselect <= csr_wrdata[1:0];
            hit <= hit | fire;
            // A tdata1 write overrides a same-cycle hit on the selected trigger.
            if (wr_td1) begin
                dmode[tselect]  <= new_dmode;
                hit[tselect]    <= csr_wrdata[20];
                sel[tselect]    <= csr_wrdata[19];
                action[tselect] <= (csr_wrdata[15:12] == 4'd1) & new_dmode;
                mt[tselect]     <= csr_wrdata[10:7] == 4'd1;
                m[tselect]      <= csr_wrdata[6];
                exe[tselect]    <= csr_wrdata[2];
                st[tselect]     <= csr_wrdata[1];
                ld[tselect]     <= csr_wrdata[0];
                if (!tselect[0])
                    chain[tselect[1]] <= csr_wrdata[11] & CHAIN_EN;
            end
            if (wr_td2)
                tdata2[tselect] <= csr_wrdata;
            trigger_dbg_req <= |(fire & action);
            trigger_brk_req <= |fire & ~|(fire & action);
            trigger_fired   <= fire;
        end
    end
endmodule

// File: tb/tb_dec_trigger_csr.sv
// tb_dec_trigger_csr: directed and random checks of dec_trigger_csr against a field-level model.
module tb_dec_trigger_csr;
    import dec_trigger_pkg::*;

    logic clk = 1'b0, rst_l = 1'b0, csr_wen = 1'b0, dbg_mode = 1'b0;
    logic [11:0] csr_addr = '0;
    logic [31:0] csr_wrdata = '0, csr_rddata;
    logic [3:0] i0_trigger_hit = '0, i1_trigger_hit = '0, trigger_fired;
    trigger_pkt_t [3:0] trigger_pkt_any;
    logic trigger_dbg_req, trigger_brk_req;
    int total = 0, bad = 0;

    bit [3:0] md_dmode, md_hit, md_sel, md_act, md_chain, md_match, md_m, md_exe, md_st, md_ld;
    logic [31:0] md_td2 [4];
    logic [1:0] md_ts;
    logic md_dbg, md_brk;
    logic [3:0] md_fired;

    dec_trigger_csr dut (
        .clk(clk), .rst_l(rst_l), .csr_wen(csr_wen), .csr_addr(csr_addr),
        .csr_wrdata(csr_wrdata), .csr_rddata(csr_rddata), .dbg_mode(dbg_mode),
        .i0_trigger_hit(i0_trigger_hit), .i1_trigger_hit(i1_trigger_hit),
        .trigger_pkt_any(trigger_pkt_any), .trigger_dbg_req(trigger_dbg_req),
        .trigger_brk_req(trigger_brk_req), .trigger_fired(trigger_fired)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        {md_dmode, md_hit, md_sel, md_act, md_chain, md_match, md_m, md_exe, md_st, md_ld} = '0;
        for (int i = 0; i < 4; i++) md_td2[i] = '0;
        md_ts = 0; md_dbg = 0; md_brk = 0; md_fired = 0;
    endtask

    function automatic logic [3:0] resolve(input logic [3:0] r);
        logic [3:0] f = r;
        for (int p = 0; p < 4; p += 2)
            if (md_chain[p]) begin
                f[p] = r[p] & r[p+1];
                f[p+1] = f[p];
            end
        return f;
    endfunction

    function automatic logic [31:0] exp_tdata1(input int i);
        return (32'd2 << 28) | (32'(md_dmode[i]) << 27) | (32'h1F << 21) | (32'(md_hit[i]) << 20)
             | (32'(md_sel[i]) << 19) | (32'(md_act[i]) << 12) | (32'(md_chain[i]) << 11)
             | (32'(md_match[i]) << 7) | (32'(md_m[i]) << 6) | (32'(md_exe[i]) << 2)
             | (32'(md_st[i]) << 1) | 32'(md_ld[i]);
    endfunction

    function automatic logic [31:0] exp_rd(input logic [11:0] a);
        if (a == 12'h7A0) return {30'b0, md_ts};
        if (a == 12'h7A1) return exp_tdata1(int'(md_ts));
        if (a == 12'h7A2) return md_td2[md_ts];
        return 32'b0;
    endfunction

    function automatic trigger_pkt_t exp_pkt(input int i);
        trigger_pkt_t p;
        p.select = md_sel[i];
        p.match = md_match[i];
        p.store = md_st[i] & ~dbg_mode;
        p.load = md_ld[i] & ~dbg_mode;
        p.execute = md_exe[i] & ~dbg_mode;
        p.m = md_m[i];
        p.tdata2 = md_td2[i];
        return p;
    endfunction

    // Next state from the inputs currently applied, evaluated just before the clock edge.
    task automatic model_clock();
        logic [3:0] q0, f;
        int t;
        logic nd;
        q0 = resolve(i0_trigger_hit);
        f = (q0 != 0) ? q0 : resolve(i0_trigger_hit | i1_trigger_hit);
        md_dbg = |(f & md_act);
        md_brk = (f != 0) && !md_dbg;
        md_fired = f;
        md_hit |= f;
        t = int'(md_ts);
        if (csr_wen) begin
            if (csr_addr == 12'h7A0 && csr_wrdata[31:2] == 0)
                md_ts = csr_wrdata[1:0];
            else if (!(md_dmode[t] && !dbg_mode)) begin
                if (csr_addr == 12'h7A1) begin
                    nd = dbg_mode ? csr_wrdata[27] : md_dmode[t];
                    md_dmode[t] = nd;
                    md_hit[t] = csr_wrdata[20];
                    md_sel[t] = csr_wrdata[19];
                    md_act[t] = (csr_wrdata[15:12] == 1) && nd;
                    md_match[t] = csr_wrdata[10:7] == 1;
                    md_m[t] = csr_wrdata[6];
                    md_exe[t] = csr_wrdata[2];
                    md_st[t] = csr_wrdata[1];
                    md_ld[t] = csr_wrdata[0];
`ifdef DEC_TRIGGER_CHAIN_EN
                    if (t == 0 || t == 2) md_chain[t] = csr_wrdata[11];
`endif
                end else if (csr_addr == 12'h7A2)
                    md_td2[t] = csr_wrdata;
            end
        end
    endtask

    task automatic check_outs();
        check("dbg_req", trigger_dbg_req, md_dbg);
        check("brk_req", trigger_brk_req, md_brk);
        check("fired", trigger_fired, md_fired);
        for (int i = 0; i < 4; i++) check($sformatf("pkt%0d", i), trigger_pkt_any[i], exp_pkt(i));
    endtask

    task automatic cycle();
        model_clock();
        @(posedge clk);
        #1;
        check_outs();
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d);
        csr_wen = 1; csr_addr = a; csr_wrdata = d;
        cycle();
        csr_wen = 0;
    endtask

    task automatic rd(input string tag, input logic [11:0] a);
        csr_addr = a;
        #1;
        check(tag, csr_rddata, exp_rd(a));
    endtask

    task automatic hit_pulse(input logic [3:0] h0, input logic [3:0] h1);
        i0_trigger_hit = h0; i1_trigger_hit = h1;
        cycle();
        i0_trigger_hit = 0; i1_trigger_hit = 0;
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_outs();
        rd("tsel_rst", 12'h7A0);
        check("tsel_rst_c", csr_rddata, 32'h0);
        rst_l = 1;
        for (int i = 0; i < 4; i++) begin
            wr(12'h7A0, i);
            rd("tdata1_rst", 12'h7A1);
            check("tdata1_rst_c", csr_rddata, 32'h23E0_0000);
        end

        wr(12'h7A0, 2);
        wr(12'h7A1, 32'h0800_104C);
        wr(12'h7A2, 32'h8000_01FF);
        rd("t2_tdata1", 12'h7A1);
        rd("t2_tdata2", 12'h7A2);
        check("pkt2_td2_c", trigger_pkt_any[2].tdata2, 32'h8000_01FF);
        check("pkt2_exe_c", trigger_pkt_any[2].execute, 1'b1);
        wr(12'h7A1, 32'h0000_00C4);
        check("pkt2_match_c", trigger_pkt_any[2].match, 1'b1);
        dbg_mode = 1;
        #1;
        check("pkt2_dbg_gate", trigger_pkt_any[2], exp_pkt(2));
        dbg_mode = 0;

        hit_pulse(4'b0000, 4'b0010);
        check("brk_t1_c", trigger_brk_req, 1'b1);
        check("fired_t1_c", trigger_fired, 4'b0010);
        cycle();
        wr(12'h7A0, 1);
        rd("t1_hit", 12'h7A1);
        check("t1_hit_c", csr_rddata[20], 1'b1);
        wr(12'h7A1, 32'h0);
        rd("t1_hit_clr", 12'h7A1);
        hit_pulse(4'b0010, 4'b0000);
        wr(12'h7A1, 32'h0000_0040);
        rd("t1_hit_vs_wr", 12'h7A1);

        wr(12'h7A0, 0);
        wr(12'h7A1, 32'h0000_0800);
        rd("t0_chain", 12'h7A1);
`ifdef DEC_TRIGGER_CHAIN_EN
        hit_pulse(4'b0001, 4'b0000);
        check("chain_alone_c", trigger_brk_req, 1'b0);
        hit_pulse(4'b0001, 4'b0010);
        check("chain_pair_c", trigger_fired, 4'b0011);
        hit_pulse(4'b0000, 4'b0010);
        check("chain_t1_only_c", trigger_fired, 4'b0000);
`else
        check("chain_off_c", csr_rddata[11], 1'b0);
        hit_pulse(4'b0001, 4'b0000);
        check("nochain_c", trigger_fired, 4'b0001);
`endif
        wr(12'h7A1, 32'h0);

        dbg_mode = 1;
        wr(12'h7A0, 3);
        wr(12'h7A1, 32'h0800_1000);
        rd("t3_dmode", 12'h7A1);
        dbg_mode = 0;
        wr(12'h7A2, 32'h1234_5678);
        rd("t3_td2_locked", 12'h7A2);
        check("t3_td2_locked_c", csr_rddata, 32'h0);
        wr(12'h7A1, 32'h0);
        rd("t3_td1_locked", 12'h7A1);
        hit_pulse(4'b1000, 4'b0000);
        check("t3_dbg_c", trigger_dbg_req, 1'b1);
        check("t3_brk_c", trigger_brk_req, 1'b0);
        hit_pulse(4'b1000, 4'b0000);
        hit_pulse(4'b1000, 4'b0001);
        check("b2b_c", trigger_fired, 4'b1000);

        wr(12'h7A0, 2);
        hit_pulse(4'b0001, 4'b0100);
        check("i0_prio_c", trigger_fired, 4'b0001);
        rd("t2_no_hit", 12'h7A1);
        check("t2_no_hit_c", csr_rddata[20], 1'b0);
        wr(12'h7A0, 5);
        rd("tsel_warl", 12'h7A0);
        check("tsel_warl_c", csr_rddata, 32'd2);
        wr(12'h7A1, 32'h0000_0100);
        rd("match_warl", 12'h7A1);
        wr(12'h7A1, 32'h0000_2000);
        rd("action_warl", 12'h7A1);
        csr_addr = 12'h7A5;
        wr(12'h7A5, 32'hFFFF_FFFF);
        rd("unmapped", 12'h7A5);

        for (int n = 0; n < 400; n++) begin
            logic [11:0] addrs [4] = '{12'h7A0, 12'h7A1, 12'h7A2, 12'h7B3};
            dbg_mode = ($urandom_range(0, 7) == 0);
            csr_wen = ($urandom_range(0, 2) == 0);
            csr_addr = addrs[$urandom_range(0, 3)];
            csr_wrdata = $urandom;
            if (csr_addr == 12'h7A0 && $urandom_range(0, 3) != 0) csr_wrdata = $urandom_range(0, 3);
            i0_trigger_hit = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0;
            i1_trigger_hit = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0;
            cycle();
            csr_wen = 0;
            rd("rand_rd", addrs[$urandom_range(0, 3)]);
        end
        i0_trigger_hit = 0; i1_trigger_hit = 0; dbg_mode = 0;

        wr(12'h7A0, 1);
        wr(12'h7A2, 32'hCAFE_0001);
        hit_pulse(4'b0100, 4'b0000);
        rst_l = 0;
        model_reset();
        #1;
        check_outs();
        rd("rst_mid_tsel", 12'h7A0);
        rd("rst_mid_td2", 12'h7A2);
        check("rst_mid_pulse_c", {trigger_dbg_req, trigger_brk_req}, 2'b00);
        #1;
        rst_l = 1;
        cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
